// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: mode codes, FSM states,
// per-mode initial patterns and small pattern helpers.
package led_seq_pkg;

    localparam int unsigned NUM_LEDS_DEF = 4;
    localparam int unsigned MODE_W       = 2;
    localparam int unsigned PAT_W        = 4;

    localparam logic [MODE_W-1:0] MODE_BLINK  = 2'd0;
    localparam logic [MODE_W-1:0] MODE_CHASE  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BOUNCE = 2'd2;
    localparam logic [MODE_W-1:0] MODE_BINARY = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [PAT_W-1:0] INIT_BLINK  = 4'b1111;
    localparam logic [PAT_W-1:0] INIT_CHASE  = 4'b0001;
    localparam logic [PAT_W-1:0] INIT_BOUNCE = 4'b0001;
    localparam logic [PAT_W-1:0] INIT_BINARY = 4'b0000;

    // Pattern loaded when a mode is (re)started.
    function automatic logic [PAT_W-1:0] init_pattern(input logic [MODE_W-1:0] m);
        logic [PAT_W-1:0] p;
        case (m)
            MODE_BLINK:  p = INIT_BLINK;
            MODE_CHASE:  p = INIT_CHASE;
            MODE_BOUNCE: p = INIT_BOUNCE;
            default:     p = INIT_BINARY;
        endcase
        return p;
    endfunction

    // True when exactly one LED is lit.
    function automatic logic is_onehot(input logic [PAT_W-1:0] v);
        return (v == 4'b0001) || (v == 4'b0010) ||
               (v == 4'b0100) || (v == 4'b1000);
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Mode request handshake plus LED/tick outputs of the sequencer.
//   mode, mode_valid : requester -> sequencer
//   mode_ready       : sequencer -> requester
//   led, tick        : sequencer -> board / observer
interface led_sequencer_if
    import led_seq_pkg::*;
#(
    parameter int unsigned NUM_LEDS = NUM_LEDS_DEF
);
    logic [MODE_W-1:0]   mode;
    logic                mode_valid;
    logic                mode_ready;
    logic [NUM_LEDS-1:0] led;
    logic                tick;

    modport master (
        output mode,
        output mode_valid,
        input  mode_ready,
        input  led,
        input  tick
    );

    modport slave (
        input  mode,
        input  mode_valid,
        output mode_ready,
        output led,
        output tick
    );
endinterface

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a registered one-cycle tick every
// 2^PRESCALE_WIDTH clocks.
//   clk    : clock
//   rst    : synchronous active-high reset
//   tick   : registered pulse, high in the cycle after the counter wraps
//   wrap_c : combinational, high in the cycle the counter is at max
//            (i.e. the edge ending this cycle raises tick)
module led_tick_gen #(
    parameter int unsigned PRESCALE_WIDTH = 22
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic wrap_c
);
    logic [PRESCALE_WIDTH-1:0] cnt;

    assign wrap_c = (cnt == '1);

    // Counter wraps naturally from max to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt + PRESCALE_WIDTH'(1);
            tick <= wrap_c;
        end
    end
endmodule

// File: rtl/led_sequencer.sv
// Animated LED pattern sequencer. A prescaler tick steps the current
// pattern; mode requests are latched through a valid/ready handshake and
// only take effect on a tick boundary.
//   CLKIN  : system clock
//   RESET  : synchronous active-high reset
//   bus    : slave side of led_sequencer_if (mode request, LEDs, tick)
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 22,
    parameter int unsigned NUM_LEDS       = NUM_LEDS_DEF
) (
    input  logic           CLKIN,
    input  logic           RESET,
    led_sequencer_if.slave bus
);
    logic wrap_c;
    logic tick_q;

    led_tick_gen #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_tick_gen (
        .clk    (CLKIN),
        .rst    (RESET),
        .tick   (tick_q),
        .wrap_c (wrap_c)
    );

    logic [0:0]        state_q,        state_d;
    logic [MODE_W-1:0] cur_mode_q,     cur_mode_d;
    logic [MODE_W-1:0] pending_mode_q, pending_mode_d;
    logic              pending_q,      pending_d;
    logic              ready_q,        ready_d;
    logic [PAT_W-1:0]  led_q,          led_d;
    logic              dir_up_q,       dir_up_d;
    logic [MODE_W-1:0] start_mode_c;
    logic              accept_c;

    assign accept_c     = bus.mode_valid && ready_q;
    // A pending request always wins at the next tick, even from IDLE.
    assign start_mode_c = pending_q ? pending_mode_q : cur_mode_q;

    // State and output registers.
    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            cur_mode_q     <= MODE_BLINK;
            pending_mode_q <= MODE_BLINK;
            pending_q      <= 1'b0;
            ready_q        <= 1'b1;
            led_q          <= '0;
            dir_up_q       <= 1'b1;
        end else begin
            state_q        <= state_d;
            cur_mode_q     <= cur_mode_d;
            pending_mode_q <= pending_mode_d;
            pending_q      <= pending_d;
            ready_q        <= ready_d;
            led_q          <= led_d;
            dir_up_q       <= dir_up_d;
        end
    end

    // Next-state, pattern stepping and handshake.
    always_comb begin
        state_d        = state_q;
        cur_mode_d     = cur_mode_q;
        pending_mode_d = pending_mode_q;
        pending_d      = pending_q;
        ready_d        = ready_q;
        led_d          = led_q;
        dir_up_d       = dir_up_q;

        case (state_q)
            ST_IDLE: begin
                if (wrap_c) begin
                    led_d    = init_pattern(start_mode_c);
                    dir_up_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wrap_c) begin
                    if (pending_q) begin
                        led_d    = init_pattern(pending_mode_q);
                        dir_up_d = 1'b1;
                    end else begin
                        case (cur_mode_q)
                            MODE_BLINK: led_d = ~led_q;
                            MODE_CHASE: begin
                                led_d = is_onehot(led_q) ? {led_q[2:0], led_q[3]}
                                                         : INIT_CHASE;
                            end
                            MODE_BOUNCE: begin
                                // End values are held for one tick: turn around
                                // while moving away from the end in one step.
                                if (!is_onehot(led_q)) begin
                                    led_d    = INIT_BOUNCE;
                                    dir_up_d = 1'b1;
                                end else if (dir_up_q) begin
                                    if (led_q == 4'b1000) begin
                                        led_d    = 4'b0100;
                                        dir_up_d = 1'b0;
                                    end else begin
                                        led_d = led_q << 1;
                                    end
                                end else begin
                                    if (led_q == 4'b0001) begin
                                        led_d    = 4'b0010;
                                        dir_up_d = 1'b1;
                                    end else begin
                                        led_d = led_q >> 1;
                                    end
                                end
                            end
                            default: led_d = led_q + 4'd1;
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Apply uses the pending flag as it was before this edge, so a request
        // accepted on a tick edge waits for the following tick.
        if (wrap_c && pending_q) begin
            cur_mode_d = pending_mode_q;
            pending_d  = 1'b0;
            ready_d    = 1'b1;
        end else if (accept_c) begin
            pending_mode_d = bus.mode;
            pending_d      = 1'b1;
            ready_d        = 1'b0;
        end
    end

    assign bus.led        = NUM_LEDS'(led_q);
    assign bus.tick       = tick_q;
    assign bus.mode_ready = ready_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with an 8-cycle tick period.
module tb_led_sequencer;
    import led_seq_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    led_sequencer_if #(.NUM_LEDS(4)) bus ();

    led_sequencer #(
        .PRESCALE_WIDTH(3),
        .NUM_LEDS(4)
    ) dut (
        .CLKIN (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until tick is seen; n is the number of edges taken (32 = timeout).
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.tick !== 1'b1 && n < 32);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.led !== 4'b0000) $display("FAIL reset_led: got %b expected 0000", bus.led); else passes++;
        checks++; if (bus.tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", bus.tick); else passes++;
        checks++; if (bus.mode_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.mode_ready); else passes++;
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (bus.led !== 4'b0000 || bus.tick !== 1'b0)
                $display("FAIL idle_cycle%0d: got led=%b tick=%b expected led=0000 tick=0", i, bus.led, bus.tick);
            else passes++;
        end
        step();
        checks++; if (bus.tick !== 1'b1) $display("FAIL first_tick: got %b expected 1", bus.tick); else passes++;
        checks++; if (bus.led !== 4'b1111) $display("FAIL first_led: got %b expected 1111", bus.led); else passes++;
        step();
        checks++; if (bus.tick !== 1'b0) $display("FAIL tick_width: got %b expected 0", bus.tick); else passes++;
        begin
            int n;
            wait_tick(n);
            checks++; if (n !== 7 || bus.led !== 4'b0000) $display("FAIL blink_t16: got n=%0d led=%b expected n=7 led=0000", n, bus.led); else passes++;
            wait_tick(n);
            checks++; if (n !== 8 || bus.led !== 4'b1111) $display("FAIL blink_t24: got n=%0d led=%b expected n=8 led=1111", n, bus.led); else passes++;
        end
    endtask

    task automatic test_chase();
        logic [3:0] exp_seq [4];
        int n;
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0001;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus.mode = MODE_CHASE;
        bus.mode_valid = 1'b1;
        step();
        bus.mode_valid = 1'b0;
        for (int c = 4; c <= 7; c++) begin
            checks++;
            if (bus.mode_ready !== 1'b0) $display("FAIL chase_ready_c%0d: got %b expected 0", c, bus.mode_ready); else passes++;
            if (c < 7) step();
        end
        step();
        checks++;
        if (bus.tick !== 1'b1 || bus.led !== 4'b0001 || bus.mode_ready !== 1'b1)
            $display("FAIL chase_apply: got tick=%b led=%b ready=%b expected 1 0001 1", bus.tick, bus.led, bus.mode_ready);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            checks++;
            if (n !== 8 || bus.led !== exp_seq[i])
                $display("FAIL chase_step%0d: got n=%0d led=%b expected n=8 led=%b", i, n, bus.led, exp_seq[i]);
            else passes++;
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_seq [8];
        int n;
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000;
        exp_seq[4] = 4'b0100; exp_seq[5] = 4'b0010; exp_seq[6] = 4'b0001; exp_seq[7] = 4'b0010;
        bus.mode = MODE_BOUNCE;
        bus.mode_valid = 1'b1;
        step();
        bus.mode_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_tick(n);
            checks++;
            if (n !== (i == 0 ? 7 : 8) || bus.led !== exp_seq[i])
                $display("FAIL bounce_step%0d: got n=%0d led=%b expected led=%b", i, n, bus.led, exp_seq[i]);
            else passes++;
        end
    endtask

    task automatic test_binary();
        int n;
        logic [3:0] exp_v;
        bus.mode = MODE_BINARY;
        bus.mode_valid = 1'b1;
        step();
        bus.mode_valid = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            wait_tick(n);
            exp_v = 4'(i);
            checks++;
            if (n !== (i == 0 ? 7 : 8) || bus.led !== exp_v)
                $display("FAIL binary_step%0d: got n=%0d led=%b expected led=%b", i, n, bus.led, exp_v);
            else passes++;
        end
    endtask

    task automatic test_tick_edge_request();
        int n;
        for (int i = 0; i < 7; i++) step();
        bus.mode = MODE_BLINK;
        bus.mode_valid = 1'b1;
        step();
        checks++;
        if (bus.tick !== 1'b1 || bus.led !== 4'b0001 || bus.mode_ready !== 1'b0)
            $display("FAIL edge_req_old_step: got tick=%b led=%b ready=%b expected 1 0001 0", bus.tick, bus.led, bus.mode_ready);
        else passes++;
        bus.mode = MODE_BOUNCE;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (bus.mode_ready !== 1'b0) $display("FAIL pending_ready%0d: got %b expected 0", i, bus.mode_ready); else passes++;
        end
        bus.mode_valid = 1'b0;
        wait_tick(n);
        checks++;
        if (n !== 2 || bus.led !== 4'b1111 || bus.mode_ready !== 1'b1)
            $display("FAIL edge_req_apply: got n=%0d led=%b ready=%b expected n=2 1111 1", n, bus.led, bus.mode_ready);
        else passes++;
        wait_tick(n);
        checks++;
        if (n !== 8 || bus.led !== 4'b0000)
            $display("FAIL second_req_ignored: got n=%0d led=%b expected n=8 0000", n, bus.led);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int n;
        bus.mode = MODE_CHASE;
        bus.mode_valid = 1'b1;
        step();
        bus.mode_valid = 1'b0;
        wait_tick(n);
        checks++; if (n !== 7 || bus.led !== 4'b0001) $display("FAIL mid_chase0: got n=%0d led=%b expected n=7 0001", n, bus.led); else passes++;
        wait_tick(n);
        checks++; if (n !== 8 || bus.led !== 4'b0010) $display("FAIL mid_chase1: got n=%0d led=%b expected n=8 0010", n, bus.led); else passes++;
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if (bus.led !== 4'b0000 || bus.tick !== 1'b0 || bus.mode_ready !== 1'b1)
            $display("FAIL mid_reset: got led=%b tick=%b ready=%b expected 0000 0 1", bus.led, bus.tick, bus.mode_ready);
        else passes++;
        rst = 1'b0;
        wait_tick(n);
        checks++;
        if (n !== 8 || bus.led !== 4'b1111)
            $display("FAIL post_reset_tick: got n=%0d led=%b expected n=8 1111", n, bus.led);
        else passes++;
        // Re-requesting the current mode restarts its pattern.
        bus.mode = MODE_BLINK;
        bus.mode_valid = 1'b1;
        step();
        bus.mode_valid = 1'b0;
        checks++; if (bus.mode_ready !== 1'b0) $display("FAIL same_mode_ready: got %b expected 0", bus.mode_ready); else passes++;
        wait_tick(n);
        checks++;
        if (n !== 7 || bus.led !== 4'b1111)
            $display("FAIL same_mode_restart: got n=%0d led=%b expected n=7 1111", n, bus.led);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        bus.mode = MODE_BLINK;
        bus.mode_valid = 1'b0;
        test_reset();
        test_chase();
        test_bounce();
        test_binary();
        test_tick_edge_request();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Drives the four board LEDs (D2..D5) on the HX8K build with selectable animated patterns.
- A free-running prescaler produces a periodic step tick.
- A small state machine advances the current pattern on each tick.
- Pattern changes are requested through a valid/ready handshake and take effect only on a tick boundary, so the LEDs never glitch mid-period.

Parameters:
- PRESCALE_WIDTH, 22, prescaler width; one step tick every 2^PRESCALE_WIDTH clocks (about 0.35 s at 12 MHz).
- NUM_LEDS, 4, LED output width. Patterns are defined for 4; other values are unsupported.

Ports:
- CLKIN  in  1  system clock; single clock domain.
- RESET  in  1  synchronous, active-high reset.
- MODE  in  2  requested pattern: 0 BLINK, 1 CHASE, 2 BOUNCE, 3 BINARY.
- MODE_VALID  in  1  MODE request present.
- MODE_READY  out  1  request can be accepted; transfer occurs when MODE_VALID && MODE_READY.
- LED  out  NUM_LEDS  LED drive; bit0=D2 .. bit3=D5.
- TICK  out  1  one-cycle pulse marking each pattern step.

Behaviour:
- Clock and reset: one clock, CLKIN. Reset is synchronous and active-high on RESET; all state is updated only on CLKIN rising edges.
- Reset values: prescaler=0, cur_mode=BLINK, pending=0, state=IDLE, LED=4'b0000, TICK=0, MODE_READY=1.
- Prescaler: increments every cycle and wraps max->0. On the edge where it wraps, TICK is registered high for exactly one cycle. Ticks are spaced exactly 2^PRESCALE_WIDTH cycles apart.
- First tick: occurs 2^PRESCALE_WIDTH cycles after reset deassertion.
- LED timing: LED is registered and updates on the same edge that raises TICK. The new pattern is therefore visible in the TICK-high cycle. There is no other LED latency.
- Handshake:
  - On accept, MODE is captured into pending_mode and pending=1; MODE_READY drops the next cycle.
  - While pending=1, MODE_READY=0 and MODE_VALID is ignored.
  - A request accepted in a TICK-generating cycle (prescaler==max) is not applied at that edge. It is applied at the following tick.
- Mode apply: on a tick with pending=1:
  - cur_mode<=pending_mode, pending<=0, MODE_READY returns to 1 in the TICK-high cycle.
  - LED loads the mode's initial pattern instead of stepping.
  - This also applies when the requested mode equals the current mode (pattern restarts).
  - The prescaler is never disturbed by mode changes.
- FSM states:
  - IDLE: LED=0, waiting for the first tick. On tick, load the initial pattern of cur_mode (or pending_mode if pending) and go to RUN.
  - RUN: on each tick, step the pattern. RUN is left only by RESET.
- Initial patterns and steps:
  - BLINK: initial 1111; step LED<=~LED.
  - CHASE: initial 0001; step rotate left (1000->0001).
  - BOUNCE: initial 0001 with dir=up; sequence 0001,0010,0100,1000,0100,0010,0001,0010...
    - Direction reverses at 1000 and at 0001.
    - Each end value is held for a single tick only.
  - BINARY: initial 0000; step LED<=LED+1 mod 16 (1111->0000 wraps, no carry out).
- Reset mid-operation: RESET in any cycle returns everything to reset values on that edge and discards any pending request. TICK is forced 0 even if the prescaler was at max.
- Illegal states: unreachable. Any unexpected LED value in CHASE/BOUNCE reloads 0001 at the next tick.

Decomposition:
- Package led_seq_pkg:
  - Mode encoding constants (MODE_BLINK=0, MODE_CHASE=1, MODE_BOUNCE=2, MODE_BINARY=3).
  - FSM state encoding (IDLE, RUN).
  - Initial-pattern constants per mode.
  - NUM_LEDS default.
- One sub-module, led_tick_gen:
  - Parameterised PRESCALE_WIDTH counter with registered TICK output, reset synchronous/active-high.
  - Reusable by other slow-rate blocks.
- Pattern FSM and handshake logic live in led_sequencer.

Test Plan:
Run with PRESCALE_WIDTH=3 (tick every 8 cycles).
1. Reset release at cycle 0, no requests -> LED=0000 through cycle 7. First TICK at cycle 8 with LED=1111, then 0000 at cycle 16, 1111 at cycle 24. TICK is high exactly one cycle each time.
2. Request MODE=1 at cycle 3 -> MODE_READY=0 on cycles 4..7. At cycle 8 TICK with LED=0001 and MODE_READY=1. Following ticks give 0010, 0100, 1000, 0001.
3. MODE=2 applied -> LED per tick: 0001,0010,0100,1000,0100,0010,0001,0010. No end value is repeated.
4. MODE=3 applied -> 0000 then 0001..1111, and the 17th step is 0000 (wrap).
5. MODE_VALID asserted in the cycle where prescaler==7 -> that tick steps the old mode. The new mode's initial pattern appears on the next tick, 8 cycles later. A second MODE_VALID while pending is ignored.
6. RESET asserted mid-CHASE at prescaler==7 -> next cycle LED=0000, TICK=0, MODE_READY=1, mode=BLINK. First tick arrives 8 cycles after RESET deasserts, with LED=1111.
